// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with round-robin arbitration and
// per-packet grant lock, driving a single registered output stream.
module stream_mux_rr #(
  parameter  int NUM_CH = 4,
  parameter  int WIDTH  = 8,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH-1:0]       in_last,
  output logic [NUM_CH-1:0]       in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  output logic                    out_last,
  output logic [CH_W-1:0]         out_ch,
  input  logic                    out_ready
);

  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   rr_ptr;
  logic [CH_W-1:0]   lock_ch;
  logic [CH_W-1:0]   arb_gnt;
  logic              arb_vld;
  logic [CH_W-1:0]   gnt;
  logic              gnt_vld;
  logic              load_en;
  logic              accept;
  logic              sel_last;
  logic [WIDTH-1:0]  sel_data;

  // Modulo-NUM_CH increment; explicit compare so non-power-of-2 counts wrap to 0.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_W-1:0] ch);
    return (int'(ch) == NUM_CH - 1) ? '0 : ch + CH_W'(1);
  endfunction

  // Round-robin search starting at rr_ptr. Iterating from the farthest offset
  // down lets the nearest valid channel overwrite earlier candidates.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves it unassigned (no latch).
    arb_gnt = rr_ptr;
    arb_vld = 1'b0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (in_valid[(int'(rr_ptr) + k) % NUM_CH]) begin
        arb_gnt = CH_W'((int'(rr_ptr) + k) % NUM_CH);
        arb_vld = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ARB;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so all flops update from pre-edge values.
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB:  if (accept && !sel_last) state_d = LOCK;
      LOCK: if (accept &&  sel_last) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  // Output/grant logic. Reset gating keeps in_ready low while rst_n is held.
  always_comb begin
    gnt      = (state_q == LOCK) ? lock_ch : arb_gnt;
    gnt_vld  = rst_n && ((state_q == LOCK) ? in_valid[lock_ch] : arb_vld);
    load_en  = !out_valid || out_ready;
    accept   = load_en && gnt_vld;
    sel_data = in_data[int'(gnt)*WIDTH +: WIDTH];
    sel_last = in_last[gnt];
    in_ready = '0;
    in_ready[gnt] = accept;
  end

  // Arbitration pointer and packet-lock owner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr  <= '0;
      lock_ch <= '0;
    end else if (accept) begin
      if (sel_last) begin
        rr_ptr <= next_ch(gnt);
      end else if (state_q == ARB) begin
        lock_ch <= gnt;
      end
    end
  end

  // Output register: loads whenever empty or draining, so throughput is 1 beat/clk.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_ch    <= '0;
    end else if (load_en) begin
      out_valid <= accept;
      if (accept) begin
        out_data <= sel_data;
        out_last <= sel_last;
        out_ch   <= gnt;
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: a 4-channel instance covers reset, round-robin,
// packet lock, backpressure and mid-packet reset; a 3-channel instance covers wrap.
module tb_stream_mux_rr;

  logic        clk;
  logic        rst_n;

  logic [31:0] in_data4;
  logic [3:0]  in_valid4, in_last4, in_ready4;
  logic [7:0]  out_data4;
  logic        out_valid4, out_last4, out_ready4;
  logic [1:0]  out_ch4;

  logic [23:0] in_data3;
  logic [2:0]  in_valid3, in_last3, in_ready3;
  logic [7:0]  out_data3;
  logic        out_valid3, out_last3, out_ready3;
  logic [1:0]  out_ch3;

  int vectors;
  int miscompares;

  stream_mux_rr #(.NUM_CH(4), .WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data4), .in_valid(in_valid4), .in_last(in_last4), .in_ready(in_ready4),
    .out_data(out_data4), .out_valid(out_valid4), .out_last(out_last4), .out_ch(out_ch4),
    .out_ready(out_ready4)
  );

  stream_mux_rr #(.NUM_CH(3), .WIDTH(8)) dut3 (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data3), .in_valid(in_valid3), .in_last(in_last3), .in_ready(in_ready3),
    .out_data(out_data3), .out_valid(out_valid3), .out_last(out_last3), .out_ch(out_ch3),
    .out_ready(out_ready3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set4(input int ch, input logic [7:0] d, input logic v, input logic l);
    in_data4[ch*8 +: 8] = d;
    in_valid4[ch]       = v;
    in_last4[ch]        = l;
  endtask

  task automatic check_out4(input string tag, input logic [7:0] d, input logic [1:0] ch,
                            input logic l);
    check({tag, ".valid"}, 32'(out_valid4), 32'd1);
    check({tag, ".data"},  32'(out_data4),  32'(d));
    check({tag, ".ch"},    32'(out_ch4),    32'(ch));
    check({tag, ".last"},  32'(out_last4),  32'(l));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;

    // Reset held with every channel requesting.
    rst_n      = 1'b0;
    out_ready4 = 1'b1;
    out_ready3 = 1'b1;
    for (int c = 0; c < 4; c++) set4(c, 8'hA0 + 8'(c), 1'b1, 1'b1);
    for (int c = 0; c < 3; c++) begin
      in_data3[c*8 +: 8] = 8'hB0 + 8'(c);
    end
    in_valid3 = 3'b111;
    in_last3  = 3'b111;
    #12;
    check("rst.out_valid4", 32'(out_valid4), 32'd0);
    check("rst.in_ready4",  32'(in_ready4),  32'd0);
    check("rst.out_ch4",    32'(out_ch4),    32'd0);
    check("rst.in_ready3",  32'(in_ready3),  32'd0);
    #10;
    rst_n = 1'b1;
    #1;

    // Round-robin over single-beat packets; 3-channel instance wraps at 2.
    for (int k = 0; k < 5; k++) begin
      check($sformatf("rr%0d.in_ready4", k), 32'(in_ready4), 32'(4'b0001 << (k % 4)));
      check($sformatf("rr%0d.in_ready3", k), 32'(in_ready3), 32'(3'b001 << (k % 3)));
      step();
      check_out4($sformatf("rr%0d", k), 8'hA0 + 8'(k % 4), 2'(k % 4), 1'b1);
      check($sformatf("rr%0d.ch3", k),   32'(out_ch3),   32'(k % 3));
      check($sformatf("rr%0d.data3", k), 32'(out_data3), 32'(8'hB0 + 8'(k % 3)));
    end
    in_valid3 = 3'b000;

    // Packet lock on ch2 with ch0/ch1 competing and a 2-cycle gap.
    in_valid4 = 4'b0000;
    set4(2, 8'h11, 1'b1, 1'b0);
    #1;
    check("lock.b1.in_ready", 32'(in_ready4), 32'b0100);
    step();
    check_out4("lock.b1", 8'h11, 2'd2, 1'b0);
    set4(0, 8'h55, 1'b1, 1'b1);
    set4(1, 8'h66, 1'b1, 1'b1);
    set4(2, 8'h22, 1'b1, 1'b0);
    #1;
    check("lock.b2.in_ready", 32'(in_ready4), 32'b0100);
    step();
    check_out4("lock.b2", 8'h22, 2'd2, 1'b0);
    set4(2, 8'h22, 1'b0, 1'b0);
    #1;
    check("lock.gap1.in_ready", 32'(in_ready4), 32'd0);
    step();
    check("lock.gap1.out_valid", 32'(out_valid4), 32'd0);
    check("lock.gap2.in_ready", 32'(in_ready4), 32'd0);
    step();
    check("lock.gap2.out_valid", 32'(out_valid4), 32'd0);
    set4(2, 8'h33, 1'b1, 1'b1);
    #1;
    check("lock.b3.in_ready", 32'(in_ready4), 32'b0100);
    step();
    check_out4("lock.b3", 8'h33, 2'd2, 1'b1);
    set4(2, 8'h00, 1'b0, 1'b0);
    #1;
    check("lock.after.in_ready", 32'(in_ready4), 32'b0001);
    step();
    check_out4("lock.after", 8'h55, 2'd0, 1'b1);

    // Backpressure: ch1 beat 66 held for 3 cycles while ch1 offers 77.
    set4(0, 8'h00, 1'b0, 1'b0);
    #1;
    check("bp.pre.in_ready", 32'(in_ready4), 32'b0010);
    step();
    check_out4("bp.pre", 8'h66, 2'd1, 1'b1);
    out_ready4 = 1'b0;
    set4(1, 8'h77, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("bp%0d.in_ready", k), 32'(in_ready4), 32'd0);
      step();
      check_out4($sformatf("bp%0d", k), 8'h66, 2'd1, 1'b1);
    end
    out_ready4 = 1'b1;
    #1;
    check("bp.resume.in_ready", 32'(in_ready4), 32'b0010);
    step();
    check_out4("bp.resume", 8'h77, 2'd1, 1'b1);
    set4(1, 8'h00, 1'b0, 1'b0);
    #1;
    check("bp.drain.in_ready", 32'(in_ready4), 32'd0);
    step();
    check("bp.drain.out_valid", 32'(out_valid4), 32'd0);

    // Reset in the middle of a ch1 4-beat packet.
    set4(1, 8'hD1, 1'b1, 1'b0);
    step();
    check_out4("rstmid.b1", 8'hD1, 2'd1, 1'b0);
    set4(1, 8'hD2, 1'b1, 1'b0);
    step();
    check_out4("rstmid.b2", 8'hD2, 2'd1, 1'b0);
    set4(0, 8'hC0, 1'b1, 1'b1);
    set4(1, 8'hD3, 1'b1, 1'b0);
    set4(2, 8'hC2, 1'b1, 1'b1);
    set4(3, 8'hC3, 1'b1, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstmid.out_valid", 32'(out_valid4), 32'd0);
    check("rstmid.in_ready",  32'(in_ready4),  32'd0);
    #10;
    rst_n = 1'b1;
    #1;
    check("rstmid.rel.in_ready", 32'(in_ready4), 32'b0001);
    step();
    check_out4("rstmid.rel", 8'hC0, 2'd0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
